// File: rtl/i2c_master_nbyte.sv
// Multi-byte I2C master: programmable SCL divider, runtime 7-bit address and byte count,
// MSB-first framing, master ACK/NACK on reads, slave NACK abort, byte-level host handshake.
module i2c_master_nbyte #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       data_in,
    output logic             wr_ready,
    output logic [7:0]       data_out,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic [3:0]       state,
    output logic             sclk,
    output logic             sda_out,
    input  logic             sda_in
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START     = 4'd1,
        ADDR      = 4'd2,
        ADDR_ACK  = 4'd3,
        WRITE     = 4'd4,
        WRITE_ACK = 4'd5,
        READ      = 4'd6,
        READ_ACK  = 4'd7,
        STOP      = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         qtr;
    logic [2:0]         bit_cnt;
    logic [7:0]         sr;
    logic               rw_q;
    logic [LEN_W-1:0]   left;
    logic               nack_q;
    logic               sclk_q, sda_q, sclk_d, sda_d;
    logic [7:0]         data_out_q;
    logic               rd_valid_q;
    logic               tick, accept, bit_sda, last_byte;

    assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_byte = (left == LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = START;
            START:     if (tick && qtr == 2'd1) state_d = ADDR;
            ADDR:      if (tick && qtr == 2'd3 && bit_cnt == 3'd0) state_d = ADDR_ACK;
            ADDR_ACK:  if (tick && qtr == 2'd3) begin
                           if (sda_in || left == '0) state_d = STOP;
                           else if (rw_q)            state_d = READ;
                           else                      state_d = WRITE;
                       end
            WRITE:     if (tick && qtr == 2'd3 && bit_cnt == 3'd0) state_d = WRITE_ACK;
            WRITE_ACK: if (tick && qtr == 2'd3) state_d = (sda_in || last_byte) ? STOP : WRITE;
            READ:      if (tick && qtr == 2'd3 && bit_cnt == 3'd0) state_d = READ_ACK;
            READ_ACK:  if (tick && qtr == 2'd3) state_d = last_byte ? STOP : READ;
            STOP:      if (tick && qtr == 2'd2) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state_q == IDLE) && start;
        done     = (state_q == STOP) && tick && (qtr == 2'd2);
        wr_ready = (state_q == WRITE) && tick && (qtr == 2'd0) && (bit_cnt == 3'd7);
        busy     = (state_q != IDLE) && !done;
        case (state_q)
            ADDR, WRITE: bit_sda = wr_ready ? data_in[7] : sr[7];
            READ_ACK:    bit_sda = last_byte;
            default:     bit_sda = 1'b1;
        endcase
        sclk_d = sclk_q;
        sda_d  = sda_q;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b1;
                sda_d  = 1'b1;
            end
            START: if (tick) begin
                if (qtr == 2'd0) sda_d  = 1'b0;
                else             sclk_d = 1'b0;
            end
            STOP: if (tick) begin
                case (qtr)
                    2'd0:    begin sclk_d = 1'b0; sda_d = 1'b0; end
                    2'd1:    sclk_d = 1'b1;
                    default: sda_d  = 1'b1;
                endcase
            end
            // every bit-carrying state: drive on q0 with SCL low, raise SCL on q2
            default: if (tick) begin
                if (qtr == 2'd0) begin
                    sclk_d = 1'b0;
                    sda_d  = bit_sda;
                end else if (qtr == 2'd2) begin
                    sclk_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            qtr        <= '0;
            bit_cnt    <= 3'd7;
            sr         <= '0;
            rw_q       <= 1'b0;
            left       <= '0;
            nack_q     <= 1'b0;
            sclk_q     <= 1'b1;
            sda_q      <= 1'b1;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            sclk_q     <= sclk_d;
            sda_q      <= sda_d;
            if (accept) begin
                cnt     <= '0;
                qtr     <= '0;
                bit_cnt <= 3'd7;
                sr      <= {addr, rw};
                rw_q    <= rw;
                left    <= len;
                nack_q  <= 1'b0;
            end else if (state_q != IDLE) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    qtr <= (state_d != state_q) ? 2'd0 : qtr + 2'd1;
                    if (wr_ready) begin
                        sr <= data_in;
                    end else if (qtr == 2'd3) begin
                        // bit_cnt wraps 0 -> 7, so it is ready for the next byte without a reload
                        case (state_q)
                            ADDR, WRITE: begin
                                sr      <= {sr[6:0], 1'b0};
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                            READ: begin
                                sr      <= {sr[6:0], sda_in};
                                bit_cnt <= bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) begin
                                    data_out_q <= {sr[6:0], sda_in};
                                    rd_valid_q <= 1'b1;
                                end
                            end
                            ADDR_ACK: if (sda_in) nack_q <= 1'b1;
                            WRITE_ACK: begin
                                if (sda_in) nack_q <= 1'b1;
                                else        left   <= left - LEN_W'(1);
                            end
                            READ_ACK: left <= left - LEN_W'(1);
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign state    = state_q;
    assign nack     = nack_q;
    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign sclk     = sclk_q;
    assign sda_out  = sda_q;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Scoreboard bench for i2c_master_nbyte: behavioural slave, bus frame decoder and
// transaction-level reference model feeding expectation queues.
module tb_i2c_master_nbyte;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LEN_W   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [3:0] len = '0;
    logic [7:0] data_in = '0;
    logic       wr_ready, rd_valid, busy, done, nack, sclk, sda_out, sda_in;
    logic [7:0] data_out;
    logic [3:0] state;

    i2c_master_nbyte #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len),
        .data_in(data_in), .wr_ready(wr_ready), .data_out(data_out), .rd_valid(rd_valid),
        .busy(busy), .done(done), .nack(nack), .state(state), .sclk(sclk),
        .sda_out(sda_out), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_chk = 0, n_fail = 0;

    task automatic chk(input bit ok, input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // slave configuration for the current transaction
    bit         sl_rw;
    int         sl_len;
    bit         sl_ack [16];
    logic [7:0] sl_rd  [16];
    logic [7:0] cur_wr [16];
    bit         sl_act = 1'b0;
    bit         sl_drive = 1'b1;

    assign sda_in = sda_out & sl_drive;

    typedef struct {
        int unsigned cyc;
        bit          nack;
        int unsigned nwr;
    } done_t;

    logic [8:0] exp_frame_q [$];
    logic [7:0] exp_rd_q    [$];
    done_t      exp_done_q  [$];

    // bus decoder / slave state
    bit          p_scl = 1'b1, p_sda = 1'b1;
    int unsigned rise_idx = 0, nbits = 0;
    logic [8:0]  frame_sh = '0;
    int unsigned wr_cnt = 0;
    bit          done_seen = 1'b0;
    logic [8:0]  exp_f;
    logic [7:0]  exp_r;
    done_t       exp_d;

    // what an ideal slave puts on SDA for SCL pulse r after START (9 pulses per byte frame)
    function automatic bit slave_bit(int unsigned r);
        int unsigned f, b;
        f = r / 9;
        b = r % 9;
        if (f == 0) return (b == 8) ? !sl_ack[0] : 1'b1;
        if (!sl_ack[0] || f > sl_len) return 1'b1;
        if (sl_rw) return (b == 8) ? 1'b1 : sl_rd[f-1][7-b];
        return (b == 8) ? !sl_ack[f] : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            p_scl = 1'b1; p_sda = 1'b1; nbits = 0; rise_idx = 0;
            sl_act = 1'b0; sl_drive = 1'b1;
        end else begin
            if (p_scl && sclk && p_sda && !sda_out) begin
                sl_act = 1'b1; rise_idx = 0; nbits = 0; sl_drive = 1'b1;
            end else if (p_scl && sclk && !p_sda && sda_out) begin
                sl_act = 1'b0; sl_drive = 1'b1; nbits = 0;
            end else if (!p_scl && sclk) begin
                frame_sh = {frame_sh[7:0], sda_out};
                nbits++;
                rise_idx++;
                if (nbits == 9) begin
                    nbits = 0;
                    chk(exp_frame_q.size() > 0, "frame_expected", exp_frame_q.size(), 1);
                    if (exp_frame_q.size() > 0) begin
                        exp_f = exp_frame_q.pop_front();
                        chk(frame_sh === exp_f, "bus_frame", frame_sh, exp_f);
                    end
                end
            end else if (p_scl && !sclk && sl_act) begin
                sl_drive = slave_bit(rise_idx);
            end
            if (wr_ready) wr_cnt++;
            if (rd_valid) begin
                chk(exp_rd_q.size() > 0, "rd_expected", exp_rd_q.size(), 1);
                if (exp_rd_q.size() > 0) begin
                    exp_r = exp_rd_q.pop_front();
                    chk(data_out === exp_r, "data_out", data_out, exp_r);
                end
            end
            if (done) begin
                chk(exp_done_q.size() > 0, "done_expected", exp_done_q.size(), 1);
                if (exp_done_q.size() > 0) begin
                    exp_d = exp_done_q.pop_front();
                    chk(cyc == exp_d.cyc, "done_cycle", cyc, exp_d.cyc);
                    chk(nack === exp_d.nack, "nack", nack, exp_d.nack);
                    chk(wr_cnt == exp_d.nwr, "wr_ready_count", wr_cnt, exp_d.nwr);
                    chk(busy === 1'b0, "busy_at_done", busy, 0);
                    chk(exp_frame_q.size() == 0, "frames_outstanding", exp_frame_q.size(), 0);
                    chk(exp_rd_q.size() == 0, "reads_outstanding", exp_rd_q.size(), 0);
                end
                done_seen = 1'b1;
            end
            p_scl = sclk;
            p_sda = sda_out;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(sclk === 1'b1, {tag, "_sclk"}, sclk, 1);
        chk(sda_out === 1'b1, {tag, "_sda_out"}, sda_out, 1);
        chk(state === 4'd0, {tag, "_state"}, state, 0);
        chk(busy === 1'b0, {tag, "_busy"}, busy, 0);
        chk(done === 1'b0, {tag, "_done"}, done, 0);
        chk(nack === 1'b0, {tag, "_nack"}, nack, 0);
        chk(wr_ready === 1'b0, {tag, "_wr_ready"}, wr_ready, 0);
        chk(rd_valid === 1'b0, {tag, "_rd_valid"}, rd_valid, 0);
        chk(data_out === 8'h00, {tag, "_data_out"}, data_out, 0);
    endtask

    task automatic all_ack();
        for (int i = 0; i < 16; i++) sl_ack[i] = 1'b1;
    endtask

    // Reference model: byte frames, reads, handshakes and completion time from the protocol rules
    task automatic run_txn(input bit t_rw, input logic [6:0] t_addr, input int t_len,
                           input bit spur, input int unsigned abort_at);
        int unsigned ndata, nwr, q, a, spur_at, limit;
        bit          t_nack;
        ndata = 0; nwr = 0; t_nack = 1'b0;
        sl_rw = t_rw;
        sl_len = t_len;
        exp_frame_q.push_back({t_addr, t_rw, 1'b1});
        if (!sl_ack[0]) t_nack = 1'b1;
        else begin
            for (int i = 1; i <= t_len; i++) begin
                ndata++;
                if (t_rw) begin
                    exp_frame_q.push_back({8'hFF, (i == t_len)});
                    exp_rd_q.push_back(sl_rd[i-1]);
                end else begin
                    exp_frame_q.push_back({cur_wr[i-1], 1'b1});
                    nwr++;
                    if (!sl_ack[i]) begin
                        t_nack = 1'b1;
                        break;
                    end
                end
            end
        end
        q = 2 + 36 * (1 + ndata) + 3;

        for (int k = 0; k < 100 && state != 4'd0; k++) @(posedge clk);
        @(posedge clk); #1;
        rw = t_rw; addr = t_addr; len = 4'(t_len); data_in = cur_wr[0];
        wr_cnt = 0; done_seen = 1'b0;
        start = 1'b1;
        a = cyc;
        if (abort_at == 0) exp_done_q.push_back('{cyc: a + CLK_DIV * q, nack: t_nack, nwr: nwr});
        limit   = (abort_at != 0) ? abort_at : CLK_DIV * q - 8;
        spur_at = $urandom_range(2, limit - 1);

        for (int unsigned k = 1; k <= CLK_DIV * q + 100; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 1) begin
                chk(busy === 1'b1, "busy_after_accept", busy, 1);
                chk(nack === 1'b0, "nack_cleared_on_start", nack, 0);
            end
            data_in = cur_wr[wr_cnt & 15];
            if (spur && k == spur_at) begin
                start = 1'b1;
                rw    = 1'($urandom);
                addr  = 7'($urandom);
                len   = 4'($urandom);
            end
            if (abort_at != 0 && k == abort_at) begin
                #1 rst = 1'b0;
                #1;
                start = 1'b0;
                check_reset_outputs("abort");
                exp_frame_q.delete();
                exp_rd_q.delete();
                exp_done_q.delete();
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            if (done_seen) break;
        end
        chk(done_seen, "done_seen_in_time", done_seen, 1);
        if (!done_seen) exp_done_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        all_ack();
        cur_wr[0] = 8'hA5; cur_wr[1] = 8'h3C;
        run_txn(1'b0, 7'h50, 2, 1'b1, 0);

        sl_rd[0] = 8'hC3; sl_rd[1] = 8'h7E;
        run_txn(1'b1, 7'h51, 2, 1'b0, 0);

        sl_ack[0] = 1'b0;
        cur_wr[0] = 8'h11; cur_wr[1] = 8'h22; cur_wr[2] = 8'h33;
        run_txn(1'b0, 7'h2A, 3, 1'b0, 0);

        all_ack();
        sl_ack[2] = 1'b0;
        cur_wr[0] = 8'h9E; cur_wr[1] = 8'h47; cur_wr[2] = 8'hD2;
        run_txn(1'b0, 7'h33, 3, 1'b0, 0);

        all_ack();
        run_txn(1'b0, 7'h3F, 0, 1'b0, 0);

        cur_wr[0] = 8'h5A; cur_wr[1] = 8'hF0; cur_wr[2] = 8'h0F;
        run_txn(1'b0, 7'h12, 3, 1'b1, CLK_DIV * (2 + 36 + 36 + 14));
        repeat (2) @(posedge clk);
        run_txn(1'b1, 7'h3F, 0, 1'b0, 0);

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 16; i++) begin
                sl_ack[i] = ($urandom_range(0, 7) != 0);
                sl_rd[i]  = 8'($urandom);
                cur_wr[i] = 8'($urandom);
            end
            run_txn(1'($urandom), 7'($urandom), int'($urandom_range(0, 6)),
                    1'($urandom), 0);
        end

        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: actual time %0t, required completion before it", $time);
        $fatal(1);
    end

endmodule
